fixed_p_narrow_saturate: RTL

- Back end of the fixed-point datapath. Consumes the pre-shifted 64-bit word plus per-element rounding-increment bits produced by the lane's rounding logic.
- Adds the increment and, for narrowing clips, saturates each element to destination SEW.
- Packs two narrowed half-words into one 64-bit result and keeps the sticky vxsat flag.
- Sits between the lane shifter and the VRF write-back, with valid/ready on both sides.

---
 rtl/ara_pkg.sv | 56 +++++
 rtl/fixed_p_narrow_saturate_clip.sv | 107 ++++++++++
 rtl/fixed_p_narrow_saturate.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ara_pkg.sv
// Shared types for the fixed-point back end: element/word types, the ops and
// element widths it understands, the packing state and the clip-bound helper.
package ara_pkg;

    localparam int unsigned ELEN = 64;
    typedef logic [ELEN-1:0] elen_t;

    localparam int unsigned DataWidth = $bits(elen_t);
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        VSSRA,
        VSSRL,
        VNCLIP,
        VNCLIPU
    } ara_op_e;

    typedef enum logic [1:0] {
        EW8,
        EW16,
        EW32,
        EW64
    } vew_e;

    // One narrowed half of a packed result word.
    typedef logic [31:0] narrow_half_t;

    typedef enum logic {
        PACK_EMPTY,
        PACK_LOW_HELD
    } pack_state_e;

    // Widest narrowing source is 64 bits; +1 for the increment carry, +1 so the
    // zero-extended unsigned case still compares correctly as a signed value.
    localparam int unsigned ClipWidth = 66;

    typedef struct packed {
        logic [ClipWidth-1:0] max_val;
        logic [ClipWidth-1:0] min_val;
    } clip_bounds_t;

    // Saturation window of a SEW-bit destination element, as ClipWidth-bit
    // two's-complement values.
    function automatic clip_bounds_t clip_bounds(input int unsigned sew, input logic is_signed);
        clip_bounds_t b;
        if (is_signed) begin
            b.max_val = (66'sd1 <<< (sew - 1)) - 66'sd1;
            b.min_val = -(66'sd1 <<< (sew - 1));
        end else begin
            b.max_val = (66'sd1 <<< sew) - 66'sd1;
            b.min_val = '0;
        end
        return b;
    endfunction

endpackage

// File: rtl/fixed_p_narrow_saturate_clip.sv
// Combinational rounding-add and clip. Produces the narrowed 32-bit half for
// VNCLIP/VNCLIPU, the full-width modular sum for VSSRA/VSSRL, and one
// saturation bit per narrowing source element. A narrowing op with EW64 is
// reported as non-narrowing so the caller treats it as VSSRL.
module fixed_p_narrow_saturate_clip
    import ara_pkg::*;
(
    input  elen_t        operand_i,
    input  logic [7:0]   r_i,
    input  ara_op_e      op_i,
    input  vew_e         vew_i,
    output narrow_half_t half_o,
    output elen_t        full_o,
    output logic [3:0]   sat_o,
    output logic         narrow_o
);

    logic         is_signed;
    narrow_half_t half_sel [3];
    logic [3:0]   sat_sel  [3];
    elen_t        full_sel [4];

    assign is_signed = (op_i == VNCLIP);
    assign narrow_o  = ((op_i == VNCLIP) || (op_i == VNCLIPU)) && (vew_i != EW64);

    // Narrowing datapaths for destination SEW = 8, 16, 32.
    for (genvar gs = 0; gs < 3; gs++) begin : g_narrow
        localparam int unsigned SEW = 8 << gs;
        localparam int unsigned SW  = 2 * SEW;
        localparam int unsigned NE  = 32 / SEW;
        localparam clip_bounds_t SBounds = clip_bounds(SEW, 1'b1);
        localparam clip_bounds_t UBounds = clip_bounds(SEW, 1'b0);

        clip_bounds_t bnd;
        narrow_half_t half_g;
        logic [3:0]   sat_g;

        assign bnd = is_signed ? SBounds : UBounds;

        for (genvar gi = 0; gi < NE; gi++) begin : g_elem
            logic [SW-1:0]        src;
            logic [ClipWidth-1:0] ext;
            logic signed [ClipWidth-1:0] sum;
            logic [SEW-1:0]       val;
            logic                 sat;

            assign src = operand_i[SW*gi +: SW];
            assign ext = is_signed ? {{(ClipWidth-SW){src[SW-1]}}, src}
                                   : {{(ClipWidth-SW){1'b0}}, src};
            assign sum = $signed(ext) + $signed({{(ClipWidth-1){1'b0}}, r_i[gi]});

            // Clamp the rounded source element into the destination range.
            always_comb begin
                val = sum[SEW-1:0];
                sat = 1'b0;
                if (sum > $signed(bnd.max_val)) begin
                    val = bnd.max_val[SEW-1:0];
                    sat = 1'b1;
                end else if (sum < $signed(bnd.min_val)) begin
                    val = bnd.min_val[SEW-1:0];
                    sat = 1'b1;
                end
            end

            assign half_g[SEW*gi +: SEW] = val;
            assign sat_g[gi]             = sat;
        end

        if (NE < 4) begin : g_sat_pad
            assign sat_g[3:NE] = '0;
        end

        assign half_sel[gs] = half_g;
        assign sat_sel[gs]  = sat_g;
    end

    // Non-narrowing datapaths: per-element add modulo 2^SEW for SEW = 8..64.
    for (genvar gs = 0; gs < 4; gs++) begin : g_wide
        localparam int unsigned SEW = 8 << gs;
        localparam int unsigned NE  = 64 / SEW;

        elen_t full_g;

        for (genvar gi = 0; gi < NE; gi++) begin : g_elem
            assign full_g[SEW*gi +: SEW] = operand_i[SEW*gi +: SEW] + {{(SEW-1){1'b0}}, r_i[gi]};
        end

        assign full_sel[gs] = full_g;
    end

    // Select the datapath matching the element width.
    always_comb begin
        half_o = '0;
        sat_o  = '0;
        full_o = full_sel[vew_i];
        case (vew_i)
            EW8:     begin half_o = half_sel[0]; sat_o = sat_sel[0]; end
            EW16:    begin half_o = half_sel[1]; sat_o = sat_sel[1]; end
            EW32:    begin half_o = half_sel[2]; sat_o = sat_sel[2]; end
            default: ;
        endcase
        if (!narrow_o) begin
            sat_o = '0;
        end
    end

endmodule

// File: rtl/fixed_p_narrow_saturate.sv
// Fixed-point back end: rounding add, narrowing clip, packing of two narrowed
// halves into one 64-bit word, sticky vxsat, valid/ready on both sides.
// Optional saturation-event counter enabled by FIXED_P_SAT_STATS_EN.
module fixed_p_narrow_saturate
    import ara_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  elen_t       operand_i,
    input  logic [7:0]  r_i,
    input  ara_op_e     op_i,
    input  vew_e        vew_i,
    input  logic        last_i,
    input  logic        valid_i,
    output logic        ready_o,
    output elen_t       result_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        vxsat_clr_i,
    output logic        vxsat_o
`ifdef FIXED_P_SAT_STATS_EN
    ,
    output logic [15:0] sat_count_o
`endif
);

    narrow_half_t half;
    elen_t        full;
    logic [3:0]   sat;
    logic         narrow;
    logic         accept;

    pack_state_e  state_q, state_d;
    narrow_half_t low_q, low_d;
    elen_t        result_q, result_d;
    logic         valid_q, valid_d;
    logic         vxsat_q, vxsat_d;

    fixed_p_narrow_saturate_clip u_clip (
        .operand_i (operand_i),
        .r_i       (r_i),
        .op_i      (op_i),
        .vew_i     (vew_i),
        .half_o    (half),
        .full_o    (full),
        .sat_o     (sat),
        .narrow_o  (narrow)
    );

    assign ready_o  = !valid_q || ready_i;
    assign accept   = valid_i && ready_o;
    assign result_o = result_q;
    assign valid_o  = valid_q;
    assign vxsat_o  = vxsat_q;

    // Packing FSM, output register and sticky saturation flag.
    always_comb begin
        state_d  = state_q;
        low_d    = low_q;
        result_d = result_q;
        valid_d  = valid_q && !ready_i;
        vxsat_d  = vxsat_q && !vxsat_clr_i;
        if (accept) begin
            if (narrow) begin
                if (|sat) begin
                    vxsat_d = 1'b1;
                end
                if (state_q == PACK_LOW_HELD) begin
                    result_d = {half, low_q};
                    valid_d  = 1'b1;
                    state_d  = PACK_EMPTY;
                    low_d    = '0;
                end else if (last_i) begin
                    result_d = {32'h0, half};
                    valid_d  = 1'b1;
                end else begin
                    low_d   = half;
                    state_d = PACK_LOW_HELD;
                end
            end else begin
                // A wide beat while a half is held drops that half.
                result_d = full;
                valid_d  = 1'b1;
                state_d  = PACK_EMPTY;
                low_d    = '0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PACK_EMPTY;
            low_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            vxsat_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            low_q    <= low_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            vxsat_q  <= vxsat_d;
        end
    end

`ifdef FIXED_P_SAT_STATS_EN
    logic [15:0] sat_count_q, sat_count_d;
    logic [16:0] sat_count_sum;

    // Add this beat's clipped-element count to the (possibly cleared) total.
    always_comb begin
        sat_count_d   = vxsat_clr_i ? 16'h0 : sat_count_q;
        sat_count_sum = {1'b0, sat_count_d};
        if (accept && narrow) begin
            sat_count_sum = {1'b0, sat_count_d} + {14'h0, 3'($countones(sat))};
        end
        sat_count_d = sat_count_sum[16] ? 16'hFFFF : sat_count_sum[15:0];
    end

    // Saturation-event counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count_o = sat_count_q;
`endif

`ifndef SYNTHESIS
    // A narrowing op cannot target 64-bit elements.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (accept && ((op_i == VNCLIP) || (op_i == VNCLIPU))) |-> (vew_i != EW64));
    // Only a narrowing beat may complete a held low half.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (accept && (state_q == PACK_LOW_HELD)) |-> narrow);
`endif

endmodule
